// File: rtl/toggle_counter_pkg.sv
// Shared mode encoding and default width for the toggle_counter block.
package toggle_counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;

endpackage

// File: rtl/toggle_counter_cell.sv
// One-bit T flip-flop with async active-low reset, load and toggle.
module toggle_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic load_val,
  input  logic tgl,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= RESET_VAL;
    else if (load) q <= load_val;
    else if (tgl)  q <= ~q;
  end

endmodule

// File: rtl/toggle_counter.sv
// Multi-bit T flip-flop register / synchronous up-down counter with load,
// terminal-count and change flags. Define TOGGLE_COUNTER_SAT_EN to saturate.
module toggle_counter
  import toggle_counter_pkg::*;
#(
  parameter int                 WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             changed
);

  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] tgl;
  logic             counting;
  logic             at_bound;
  logic             tc_d;
  logic             changed_d;

  // Ripple AND chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  genvar i;
  generate
    for (i = 1; i < WIDTH; i++) begin : g_terms
      assign up_t[i] = up_t[i-1] & q[i-1];
      assign dn_t[i] = dn_t[i-1] & ~q[i-1];
    end
  endgenerate

  assign counting = en && ((mode == MODE_UP) || (mode == MODE_DOWN));
  assign at_bound = ((mode == MODE_UP) && (&q)) || ((mode == MODE_DOWN) && !(|q));

  always_comb begin
    tgl = '0;
    if (!load && en) begin
      case (mode)
        MODE_TOGGLE: tgl = t;
        MODE_UP:     tgl = up_t;
        MODE_DOWN:   tgl = dn_t;
        default:     tgl = '0;
      endcase
`ifdef TOGGLE_COUNTER_SAT_EN
      // Stalled at the boundary: hold q but keep reporting tc.
      if (counting && at_bound) tgl = '0;
`endif
    end
  end

  assign tc_d      = !load && counting && at_bound;
  assign changed_d = load ? (load_val != q) : (|tgl);

  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      toggle_cell #(
        .RESET_VAL (RESET_VAL[i])
      ) u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val[i]),
        .tgl      (tgl[i]),
        .q        (q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc      <= 1'b0;
      changed <= 1'b0;
    end else begin
      tc      <= tc_d;
      changed <= changed_d;
    end
  end

endmodule

// File: tb/tb_toggle_counter.sv
// Self-checking bench for toggle_counter (WIDTH=4) against an arithmetic model.
module tb_toggle_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] t;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         changed;

  int n_tests = 0;
  int n_fail  = 0;

  int m_q  = 0;
  int m_tc = 0;
  int m_ch = 0;

  toggle_counter #(.WIDTH(W), .RESET_VAL(4'h0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .t        (t),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic modulo 16.
  task automatic model_edge();
    int nq;
    int top;
    top = (1 << W) - 1;
    nq  = m_q;
    m_tc = 0;
    m_ch = 0;
    if (load) begin
      nq   = int'(load_val);
      m_ch = (nq != m_q) ? 1 : 0;
    end else if (en) begin
      case (mode)
        2'b01: begin
          nq   = m_q ^ int'(t);
          m_ch = (t != 0) ? 1 : 0;
        end
        2'b10: begin
          if (m_q == top) begin
            m_tc = 1;
`ifdef TOGGLE_COUNTER_SAT_EN
            nq = m_q;
`else
            nq = 0;
`endif
          end else nq = m_q + 1;
          m_ch = (nq != m_q) ? 1 : 0;
        end
        2'b11: begin
          if (m_q == 0) begin
            m_tc = 1;
`ifdef TOGGLE_COUNTER_SAT_EN
            nq = m_q;
`else
            nq = top;
`endif
          end else nq = m_q - 1;
          m_ch = (nq != m_q) ? 1 : 0;
        end
        default: ;
      endcase
    end
    m_q = nq;
  endtask

  task automatic step_chk(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_q"},  int'(q),       m_q);
    check({tag, "_tc"}, int'(tc),      m_tc);
    check({tag, "_ch"}, int'(changed), m_ch);
  endtask

  task automatic drive(input logic l, input logic [W-1:0] lv, input logic e,
                       input logic [1:0] md, input logic [W-1:0] tt);
    load = l; load_val = lv; en = e; mode = md; t = tt;
  endtask

  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    m_q = 0; m_tc = 0; m_ch = 0;
    #1;
    check({tag, "_q"},  int'(q),       0);
    check({tag, "_tc"}, int'(tc),      0);
    check({tag, "_ch"}, int'(changed), 0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 2'b00, 4'h0);
    #12 rst_n = 1'b1;
    #1;
    check("rst_q", int'(q), 0);
    check("rst_tc", int'(tc), 0);
    check("rst_ch", int'(changed), 0);

    // Async reset mid-cycle with q=A
    @(negedge clk);
    drive(1'b1, 4'hA, 1'b0, 2'b00, 4'h0);
    step_chk("ldA");
    check("ldA_const", int'(q), 10);
    mid_reset("async_rst");

    // TOGGLE from 0: 5, 6, 6
    drive(1'b0, 4'h0, 1'b1, 2'b01, 4'b0101); step_chk("tog1");
    check("tog1_const", int'(q), 5);
    drive(1'b0, 4'h0, 1'b1, 2'b01, 4'b0011); step_chk("tog2");
    check("tog2_const", int'(q), 6);
    drive(1'b0, 4'h0, 1'b1, 2'b01, 4'b0000); step_chk("tog3");
    check("tog3_ch_const", int'(changed), 0);

    // UP wrap from E
    drive(1'b1, 4'hE, 1'b1, 2'b10, 4'h0); step_chk("upld");
    drive(1'b0, 4'h0, 1'b1, 2'b10, 4'h0);
    step_chk("up1"); step_chk("up2"); step_chk("up3");

    // DOWN wrap from 1
    drive(1'b1, 4'h1, 1'b1, 2'b11, 4'h0); step_chk("dnld");
    drive(1'b0, 4'h0, 1'b1, 2'b11, 4'h0);
    step_chk("dn1"); step_chk("dn2"); step_chk("dn3");

    // Priority: load beats an UP boundary step
    drive(1'b1, 4'hF, 1'b0, 2'b00, 4'h0); step_chk("prF");
    drive(1'b1, 4'h7, 1'b1, 2'b10, 4'h0); step_chk("prld");
    check("prld_tc_const", int'(tc), 0);
    drive(1'b0, 4'h0, 1'b0, 2'b10, 4'h0); step_chk("prhold");
    check("prhold_const", int'(q), 7);

    // Mode switch UP->DOWN with no extra latency
    drive(1'b1, 4'h1, 1'b0, 2'b00, 4'h0); step_chk("msld");
    drive(1'b0, 4'h0, 1'b1, 2'b10, 4'h0); step_chk("msup1"); step_chk("msup2");
    check("msup_const", int'(q), 3);
    drive(1'b0, 4'h0, 1'b1, 2'b11, 4'h0); step_chk("msdn");
    check("msdn_const", int'(q), 2);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 7) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
            2'($urandom), 4'($urandom));
      step_chk("rnd");
      if (k == 200) mid_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_counter.md
# toggle_counter

Parametrised multi-bit toggle register: the next generation of the single-bit T flip-flop. Each bit is a T flip-flop. Per-bit toggle inputs are either supplied directly (TOGGLE mode) or derived internally to form a synchronous up/down counter. The block also provides synchronous load, hold, and a registered terminal-count flag. It serves as the general-purpose toggle/count element for the Day-series sequential blocks.

## Interface
- WIDTH, 8, number of T flip-flop bits (≥ 2)
- RESET_VAL, {WIDTH{1'b0}}, value of q after reset
- clk  input  1  rising-edge clock; the single clock of the block
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  advance enable; when low, state holds (load still honoured)
- mode  input  2  00 HOLD, 01 TOGGLE, 10 COUNT_UP, 11 COUNT_DOWN
- t  input  WIDTH  per-bit toggle request, used only in TOGGLE mode
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value written on load
- q  output  WIDTH  register state
- tc  output  1  registered terminal-count pulse
- changed  output  1  registered; high for one cycle after any bit of q changed

## Operation
- Priority per rising edge: load > (en && mode) > hold.
- load=1: q <= load_val; tc <= 0; changed <= (load_val != q).
- en=0 or mode=HOLD: q holds; tc <= 0; changed <= 0.
- TOGGLE: q <= q ^ t; tc <= 0; changed <= |t.
- COUNT_UP: bit i toggle term = &q[i-1:0]; bit 0 always toggles. This is the classic T-FF synchronous counter, equivalent to q+1 mod 2^WIDTH.
- COUNT_DOWN: bit i toggle term = &(~q[i-1:0]); bit 0 always toggles. Equivalent to q-1 mod 2^WIDTH.
- Wrap-around: UP from all-ones gives 0; DOWN from 0 gives all-ones. The stepping edge sets tc <= 1.
- tc is high only for the cycle following a boundary step. It is cleared on any edge without a boundary step.
- Mode change takes effect on the very next edge with no pipeline flush. An unchanged q with en=0 does not lose state.
- No illegal mode encodings exist; all four are defined.

## Timing
- All outputs registered; latency 1 clock from input sample to q/tc/changed.
- Async reset: q = RESET_VAL, tc = 0, changed = 0, immediately on rst_n falling and independent of clk.
- Reset mid-count: the count is lost. The first edge after rst_n deasserts acts on RESET_VAL.
- rst_n deassertion is assumed synchronised upstream; the block adds no synchroniser.
- load and a boundary step on the same edge: load wins and tc=0.
- Combinational depth: WIDTH-input AND chain for the toggle terms. The chain is acceptable up to WIDTH=32 at target clock.

## Configuration
- Macro TOGGLE_COUNTER_SAT_EN.
- Defined: counting saturates. In UP at all-ones, q holds; in DOWN at 0, q holds. tc <= 1 on every edge where a step is attempted at the boundary, so tc stays high while stalled. changed <= 0 on those edges. TOGGLE mode is unaffected.
- Undefined: wrap-around as in Operation. tc is a single-cycle pulse per wrap.

## Structure
- Package toggle_counter_pkg holds:
  - the mode encoding constants MODE_HOLD, MODE_TOGGLE, MODE_UP, MODE_DOWN (2-bit);
  - the default WIDTH.
- Sub-module toggle_cell: one-bit T flip-flop with async active-low reset, reset value, load, and toggle inputs. It is instantiated WIDTH times via generate.
- The top level computes the per-bit toggle terms, the boundary detect, and the tc/changed registers.

## Test plan
All scenarios use WIDTH=4 and RESET_VAL=0.
- Reset: drive rst_n=0 mid-cycle with q=4'hA -> q=0, tc=0, changed=0 immediately, before the next edge.
- TOGGLE: q=0; apply t=4'b0101, then 4'b0011, then 4'b0000 on successive edges -> q = 5, then 6, then 6; changed = 1, 1, 0.
- COUNT_UP wrap: load 4'hE, then 3 edges in UP -> q = F, 0, 1; tc high only in the cycle after q becomes 0. With SAT_EN: q = F, F, F and tc high from the second edge onward.
- COUNT_DOWN: load 4'h1, then 3 edges in DOWN -> q = 0, F, E; tc pulses once after q becomes F.
- Priority: load=1, load_val=4'h7 with en=1, UP, q=4'hF -> q=7, tc=0. Next edge with en=0 -> q stays 7, changed=0.
- Mode switch: count UP to 3, switch to DOWN on the next edge -> q=2 with no extra latency.
